// File: rtl/axi_addr_gen_pkg.sv
// Shared definitions for the AXI burst address generator.
//   state_e      : generator FSM states (also exported on the debug port)
//   BURST_*      : AXI burst-type encodings for axburst
//   PAGE_BYTES   : size of the page that a burst must not cross when
//                  AXI_ADDR_GEN_4K_SPLIT_EN is defined
package axi_addr_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam int unsigned PAGE_BYTES = 4096;

endpackage

// File: rtl/burst_len_calc.sv
// Combinational burst length: min(rem_beats, MAX_BEATS, beats to 4 KiB page end).
// The page term exists only when AXI_ADDR_GEN_4K_SPLIT_EN is defined;
// otherwise the cap is MAX_BEATS alone.
// Ports:
//   rem_beats_i : beats still to issue (never 0 when the result is used)
//   page_off_i  : addr[11:0] of the next burst (beat aligned)
//   beats_o     : beats in the next burst, 1..MAX_BEATS
module burst_len_calc
  import axi_addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BEATS  = 16,
  parameter int AXSIZE     = 3
) (
  input  logic [ADDR_WIDTH-1:0] rem_beats_i,
  input  logic [11:0]           page_off_i,
  output logic [8:0]            beats_o
);

  localparam logic [8:0] MAX_B = 9'(MAX_BEATS);

  logic [8:0] cap;

`ifdef AXI_ADDR_GEN_4K_SPLIT_EN
  // Page offset is beat aligned, so at least one beat always fits.
  logic [12:0] to_page_bytes;
  logic [12:0] to_page_beats;

  assign to_page_bytes = 13'(PAGE_BYTES) - {1'b0, page_off_i};
  assign to_page_beats = to_page_bytes >> AXSIZE;

  always_comb begin
    cap = MAX_B;
    if (to_page_beats < {4'd0, MAX_B}) cap = to_page_beats[8:0];
  end
`else
  logic unused_page_off;
  assign unused_page_off = ^page_off_i;
  assign cap = MAX_B;
`endif

  assign beats_o = (rem_beats_i < ADDR_WIDTH'(cap)) ? rem_beats_i[8:0] : cap;

endmodule

// File: rtl/axi_burst_address_generator.sv
// AXI4 AR/AW address generator covering [startAddr, startAddr+byteCount)
// with a shortened final burst and a bounded number of outstanding bursts.
// Define AXI_ADDR_GEN_4K_SPLIT_EN to keep every burst inside a 4 KiB page.
// Ports:
//   aclk, reset       : clock, synchronous active-high reset
//   start, startAddr,
//   byteCount         : transfer request, sampled only while done=1
//   done              : idle with every burst completed
//   xferComplete      : one pulse per completed burst
//   outstanding       : bursts accepted but not yet completed
//   ax*               : AXI address channel (axvalid/axready handshake)
//   dbg_state         : current FSM state (state_e encoding)
//
// Handshake: a beat transfers on a clock edge where axvalid && axready.
// Once axvalid is high, axaddr/axlen stay constant and axvalid stays high
// until that edge; axvalid is a register, so it never depends on axready
// combinationally.
module axi_burst_address_generator
  import axi_addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH            = 32,
  parameter int ID_WIDTH              = 8,
  parameter int AXID                  = 0,
  parameter int MAX_BEATS             = 16,
  parameter int AxSIZE_BYTES_PER_BEAT = 3,
  parameter int AxBURST               = 1,
  parameter int MAX_OUTSTANDING       = 4
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] startAddr,
  input  logic [ADDR_WIDTH-1:0] byteCount,
  output logic                  done,
  input  logic                  xferComplete,
  output logic [3:0]            outstanding,
  output logic [ID_WIDTH-1:0]   axid,
  output logic [ADDR_WIDTH-1:0] axaddr,
  output logic [7:0]            axlen,
  output logic [2:0]            axsize,
  output logic [1:0]            axburst,
  output logic                  axlock,
  output logic [3:0]            axcache,
  output logic [2:0]            axprot,
  output logic                  axvalid,
  input  logic                  axready,
  output logic [1:0]            dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    ADDR_WIDTH'((1 << AxSIZE_BYTES_PER_BEAT) - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic [8:0]            beats_q, beats_d;
  logic [ADDR_WIDTH-1:0] axaddr_q, axaddr_d;
  logic [7:0]            axlen_q, axlen_d;
  logic                  axvalid_q, axvalid_d;
  logic                  done_q, done_d;
  logic [3:0]            outstanding_q, outstanding_d;

  logic [8:0] calc_beats;
  logic       hs;
  logic       dec;

  burst_len_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_BEATS  (MAX_BEATS),
    .AXSIZE     (AxSIZE_BYTES_PER_BEAT)
  ) u_len (
    .rem_beats_i (rem_q),
    .page_off_i  (addr_q[11:0]),
    .beats_o     (calc_beats)
  );

  assign hs  = axvalid_q && axready;
  // Completions with nothing outstanding are dropped so the count saturates.
  assign dec = xferComplete && (outstanding_q != 4'd0);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    beats_d       = beats_q;
    axaddr_d      = axaddr_q;
    axlen_d       = axlen_q;
    axvalid_d     = axvalid_q;
    done_d        = done_q;
    outstanding_d = outstanding_q;

    if (hs && !dec)      outstanding_d = outstanding_q + 4'd1;
    else if (dec && !hs) outstanding_d = outstanding_q - 4'd1;

    case (state_q)
      IDLE: begin
        if (start && done_q && (byteCount != '0)) begin
          addr_d  = startAddr & ~OFF_MASK;
          // Ceiling division: whole beats plus one for any partial tail.
          rem_d   = (byteCount >> AxSIZE_BYTES_PER_BEAT)
                  + ADDR_WIDTH'((byteCount & OFF_MASK) != '0);
          done_d  = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Re-registered every stall cycle; inputs are unchanged so the
        // values are stable by the time axvalid rises.
        axaddr_d = addr_q;
        axlen_d  = 8'(calc_beats - 9'd1);
        beats_d  = calc_beats;
        if (outstanding_q < 4'(MAX_OUTSTANDING)) begin
          axvalid_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          axvalid_d = 1'b0;
          addr_d    = addr_q + (ADDR_WIDTH'(beats_q) << AxSIZE_BYTES_PER_BEAT);
          rem_d     = rem_q - ADDR_WIDTH'(beats_q);
          state_d   = (rem_q == ADDR_WIDTH'(beats_q)) ? DRAIN : CALC;
        end
      end
      DRAIN: begin
        if (outstanding_q == 4'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      beats_q       <= '0;
      axaddr_q      <= '0;
      axlen_q       <= '0;
      axvalid_q     <= 1'b0;
      done_q        <= 1'b1;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      beats_q       <= beats_d;
      axaddr_q      <= axaddr_d;
      axlen_q       <= axlen_d;
      axvalid_q     <= axvalid_d;
      done_q        <= done_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign done        = done_q;
  assign outstanding = outstanding_q;
  assign axaddr      = axaddr_q;
  assign axlen       = axlen_q;
  assign axvalid     = axvalid_q;
  assign dbg_state   = state_q;

  assign axid    = ID_WIDTH'(AXID);
  assign axsize  = 3'(AxSIZE_BYTES_PER_BEAT);
  assign axburst = 2'(AxBURST);
  assign axlock  = 1'b0;
  assign axcache = 4'd0;
  assign axprot  = 3'd0;

endmodule

// File: tb/tb_axi_burst_address_generator.sv
// Self-checking bench for axi_burst_address_generator (BPB=8, MAX_BEATS=16,
// MAX_OUTSTANDING=3). Expected bursts come from a page/length model built
// with plain arithmetic; the 4 KiB term follows AXI_ADDR_GEN_4K_SPLIT_EN.
module tb_axi_burst_address_generator;
  import axi_addr_gen_pkg::*;

  localparam int AW      = 32;
  localparam int MAX_OUT = 3;

  // clock / reset
  logic aclk = 1'b0;
  logic reset = 1'b1;
  always #5 aclk = ~aclk;

  logic          start = 1'b0;
  logic [AW-1:0] startAddr = '0;
  logic [AW-1:0] byteCount = '0;
  logic          done;
  logic          xferComplete;
  logic [3:0]    outstanding;
  logic [7:0]    axid;
  logic [AW-1:0] axaddr;
  logic [7:0]    axlen;
  logic [2:0]    axsize;
  logic [1:0]    axburst;
  logic          axlock;
  logic [3:0]    axcache;
  logic [2:0]    axprot;
  logic          axvalid;
  logic          axready;
  logic [1:0]    dbg_state;

  // traffic agents
  logic ack_en = 1'b0, agent_xc = 1'b0, manual_xc = 1'b0;
  logic rdy_rand = 1'b0, rdy_agent = 1'b1, rdy_dir = 1'b1;
  int   hs_cnt = 0, ack_cnt = 0, man_cnt = 0;

  assign xferComplete = agent_xc | manual_xc;
  assign axready      = rdy_rand ? rdy_agent : rdy_dir;

  axi_burst_address_generator #(
    .ADDR_WIDTH(AW), .ID_WIDTH(8), .AXID(0), .MAX_BEATS(16),
    .AxSIZE_BYTES_PER_BEAT(3), .AxBURST(1), .MAX_OUTSTANDING(MAX_OUT)
  ) u_dut (
    .aclk(aclk), .reset(reset), .start(start), .startAddr(startAddr),
    .byteCount(byteCount), .done(done), .xferComplete(xferComplete),
    .outstanding(outstanding), .axid(axid), .axaddr(axaddr), .axlen(axlen),
    .axsize(axsize), .axburst(axburst), .axlock(axlock), .axcache(axcache),
    .axprot(axprot), .axvalid(axvalid), .axready(axready),
    .dbg_state(dbg_state)
  );

  // scoreboard
  logic [AW+7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: split the byte range into bursts by length and page rules.
  task automatic build_exp(input logic [AW-1:0] sa, input logic [AW-1:0] cnt);
    longint a, rem, b, t;
    a   = longint'(sa) & ~longint'(7);
    rem = (longint'(cnt) + 7) / 8;
    while (rem > 0) begin
      b = (rem < 16) ? rem : 16;
`ifdef AXI_ADDR_GEN_4K_SPLIT_EN
      t = (4096 - (a % 4096)) / 8;
      if (t < b) b = t;
`endif
      exp_q.push_back({a[AW-1:0], 8'(b - 1)});
      a   = (a + b * 8) % (longint'(1) << AW);
      rem = rem - b;
    end
  endtask

  // Drives xferComplete/axready for the next edge, then records the
  // handshake that edge will perform. One process avoids ordering races.
  always @(negedge aclk) begin
    logic rdy_now;
    if (reset) begin
      ack_cnt  = hs_cnt - man_cnt;
      agent_xc = 1'b0;
    end else if (ack_en && (hs_cnt - ack_cnt - man_cnt) > 0 && $urandom_range(0, 2) == 0) begin
      agent_xc = 1'b1;
      ack_cnt++;
    end else begin
      agent_xc = 1'b0;
    end
    rdy_agent = ($urandom_range(0, 3) != 0);
    rdy_now   = rdy_rand ? rdy_agent : rdy_dir;
    if (!reset && axvalid && rdy_now) begin
      hs_cnt++;
      if (exp_q.size() == 0) check("unexpected_burst", {axaddr, axlen}, 64'hdead);
      else check("burst", {axaddr, axlen}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a, input logic [AW-1:0] c);
    startAddr = a;
    byteCount = c;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && !done; i++) tick();
    check({tag, "_done"}, done, 1);
    check({tag, "_all_bursts"}, exp_q.size(), 0);
    check({tag, "_outstanding"}, outstanding, 0);
  endtask

  task automatic run_xfer(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] c);
    build_exp(a, c);
    pulse_start(a, c);
    check({tag, "_busy"}, done, 0);
    wait_done(tag);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int base;
    logic saw_valid;

    // reset state
    repeat (3) tick();
    reset = 1'b0;
    check("rst_done", done, 1);
    check("rst_axvalid", axvalid, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_axaddr", axaddr, 0);
    check("rst_axlen", axlen, 0);
    check("rst_state", dbg_state, IDLE);
    check("const_axsize", axsize, 3);
    check("const_axburst", axburst, 1);
    check("const_axid", axid, 0);
    check("const_misc", {axlock, axcache, axprot}, 0);

    // directed ranges, axready high
    ack_en = 1'b1;
    run_xfer("x256", 32'h1000, 256);
    run_xfer("x200", 32'h2000, 200);
    run_xfer("x4k", 32'h0FC0, 256);
    run_xfer("wrap", 32'hFFFF_FFC0, 128);
    run_xfer("unaligned", 32'h3003, 9);

    // zero length: no burst
    saw_valid = 1'b0;
    pulse_start(32'h8000, 0);
    for (int i = 0; i < 6; i++) begin
      if (axvalid) saw_valid = 1'b1;
      tick();
    end
    check("zero_no_valid", saw_valid, 0);
    check("zero_done", done, 1);

    // outstanding limit stalls in CALC until a completion arrives
    ack_en = 1'b0;
    base = hs_cnt;
    build_exp(32'h4000, 1024);
    pulse_start(32'h4000, 1024);
    repeat (20) tick();
    check("stall_hs", hs_cnt - base, MAX_OUT);
    check("stall_outstanding", outstanding, MAX_OUT);
    check("stall_axvalid", axvalid, 0);
    check("stall_state", dbg_state, CALC);
    manual_xc = 1'b1;
    man_cnt++;
    tick();
    manual_xc = 1'b0;
    for (int i = 0; i < 10 && (hs_cnt - base) < MAX_OUT + 1; i++) tick();
    check("resume_hs", hs_cnt - base, MAX_OUT + 1);
    ack_en = 1'b1;
    wait_done("stall");

    // axready low: channel held stable
    rdy_dir = 1'b0;
    build_exp(32'h5000, 128);
    pulse_start(32'h5000, 128);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", axvalid, 1);
      check("hold_addr_len", {axaddr, axlen}, {32'h5000, 8'd15});
      tick();
    end
    rdy_dir = 1'b1;
    wait_done("hold");

    // completion with nothing outstanding is ignored
    ack_en = 1'b0;
    manual_xc = 1'b1;
    tick();
    manual_xc = 1'b0;
    tick();
    check("sat_outstanding", outstanding, 0);

    // reset mid-transfer with MAX_OUT in flight
    build_exp(32'h6000, 1024);
    pulse_start(32'h6000, 1024);
    for (int i = 0; i < 50 && outstanding != 4'(MAX_OUT); i++) tick();
    check("mid_outstanding", outstanding, MAX_OUT);
    reset = 1'b1;
    tick();
    check("mid_rst_done", done, 1);
    check("mid_rst_axvalid", axvalid, 0);
    check("mid_rst_outstanding", outstanding, 0);
    tick();
    reset = 1'b0;
    exp_q.delete();
    ack_en = 1'b1;
    run_xfer("after_rst", 32'h7000, 64);

    // randomized ranges with random axready and completion timing
    rdy_rand = 1'b1;
    for (int n = 0; n < 15; n++)
      run_xfer("rand", $urandom(), $urandom_range(1, 700));
    rdy_rand = 1'b0;

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_burst_address_generator.md
Name: axi_burst_address_generator

Overview:
- Parametrised successor to the fixed-length linear AXI address generator.
- Issues AXI4 AR/AW address beats covering an arbitrary byte range [startAddr, startAddr+byteCount):
  - shortened final burst;
  - bounded number of outstanding bursts, using completion feedback;
  - optional 4 KiB boundary splitting.
- Sits between a DMA/stream front end (framebuffer readout, texture load) and the AXI interconnect address channel.

Parameters:
- ADDR_WIDTH, 32, address and byte-count width.
- ID_WIDTH, 8, width of axid.
- AXID, 0, constant value driven on axid.
- MAX_BEATS, 16, max beats per burst (1..256); axlen = beats-1.
- AxSIZE_BYTES_PER_BEAT, 3, log2 bytes per beat (BPB = 2^AxSIZE).
- AxBURST, 1, burst type driven on axburst.
- MAX_OUTSTANDING, 4, max accepted-but-uncompleted bursts (1..15).

Ports:
- aclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin transfer; sampled only when done=1.
- startAddr  in  ADDR_WIDTH  first byte address; low AxSIZE bits forced to 0.
- byteCount  in  ADDR_WIDTH  transfer length in bytes; rounded up to whole beats.
- done  out  1  1 = idle and all bursts completed.
- xferComplete  in  1  one pulse per completed burst (rlast&rvalid&rready or bvalid&bready).
- outstanding  out  4  bursts accepted but not yet completed.
- axid  out  ID_WIDTH  = AXID.
- axaddr  out  ADDR_WIDTH  burst start address.
- axlen  out  8  beats-1 of the current burst.
- axsize  out  3  = AxSIZE_BYTES_PER_BEAT.
- axburst  out  2  = AxBURST.
- axlock, axcache, axprot  out  1/4/3  constant 0.
- axvalid  out  1  address valid.
- axready  in  1  address ready.

Behaviour:
- Reset values: done=1, axvalid=0, outstanding=0, axaddr=0, axlen=0, state IDLE; constant outputs at their parameter values.
- Reset mid-operation abandons the transfer: in-flight bursts are no longer counted and the next start begins cleanly.
- IDLE:
  - start&&done: latch addr=startAddr&~(BPB-1) and remBeats=ceil(byteCount/BPB) (ADDR_WIDTH-bit arithmetic; no overflow beyond 2^ADDR_WIDTH-1 bytes).
  - byteCount=0: stay IDLE, done stays 1, no burst.
  - Otherwise done<=0 and go to CALC.
- CALC (1 cycle):
  - beats=min(remBeats, MAX_BEATS, beatsTo4k).
  - Register axaddr=addr and axlen=beats-1.
  - If outstanding<MAX_OUTSTANDING, go to ISSUE with axvalid<=1; else stay in CALC (stall).
- ISSUE:
  - While axvalid&&!axready, axaddr/axlen/axvalid are held stable (AXI rule).
  - On handshake: axvalid<=0, addr+=beats*BPB, remBeats-=beats, outstanding+1.
  - Then CALC if remBeats≠0, else DRAIN.
  - axvalid never deasserts without a handshake.
- DRAIN: when outstanding==0, done<=1 and go to IDLE.
- outstanding:
  - +1 on handshake, -1 on xferComplete; simultaneous events leave it unchanged.
  - xferComplete with outstanding=0 is ignored (saturates at 0).
- Throughput: one burst per 2 cycles with axready tied high (CALC+ISSUE). No combinational path from axready to axvalid.
- start while done=0 is ignored.
- Address wrap past 2^ADDR_WIDTH wraps modulo; no error.

Optional Feature:
- AXI_ADDR_GEN_4K_SPLIT_EN defined:
  - beatsTo4k=(4096-addr[11:0])>>AxSIZE.
  - No burst crosses a 4 KiB boundary.
- Not defined:
  - beatsTo4k treated as MAX_BEATS.
  - Caller guarantees alignment; bursts are MAX_BEATS except the final one.

Decomposition:
- Package axi_addr_gen_pkg holds:
  - state enum (IDLE, CALC, ISSUE, DRAIN);
  - AXI burst-type constants (FIXED=0, INCR=1, WRAP=2);
  - the 4 KiB page constant.
- One sub-module, burst_len_calc: combinational min(remBeats, MAX_BEATS, beatsTo4k), with the 4K term under the macro.
- The outstanding counter stays inline.

Test Plan:
- Bytes per beat = 8 (BPB), MAX_BEATS=16 in all cases; axready=1 unless stated.
- startAddr=0x1000, byteCount=256 -> two bursts, axaddr 0x1000/0x1080, axlen 15/15; done rises after two xferComplete pulses.
- startAddr=0x2000, byteCount=200 -> bursts axlen 15 @0x2000 and axlen 8 @0x2080 (25 beats total).
- 4K enabled, startAddr=0x0FC0, byteCount=256 -> axlen 7 @0x0FC0, 15 @0x1000, 7 @0x1080. Macro off -> 15 @0x0FC0, 15 @0x1040.
- MAX_OUTSTANDING=2, byteCount=1024, no xferComplete -> exactly 2 handshakes then stall in CALC. One xferComplete -> third burst issues.
- axready low 5 cycles during ISSUE -> axaddr/axlen/axvalid stable across all 5. byteCount=0 -> no axvalid, done stays 1.
- reset asserted mid-transfer with 3 outstanding -> next cycle done=1, axvalid=0, outstanding=0. A new start then begins at the new startAddr.
